// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage and its barrel shifter.
// The request payload is carried as one packed struct from FIFO head to shifter.
package shift_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned AMT_W  = 6;

  typedef enum logic [1:0] {
    SHIFT_LL = 2'b00,
    SHIFT_RL = 2'b01,
    SHIFT_LA = 2'b10,
    SHIFT_RA = 2'b11
  } shift_type_e;

  typedef struct packed {
    logic [DATA_W-1:0] in;
    shift_type_e       shift_type;
    logic [AMT_W-1:0]  shift_amount;
  } shift_req_t;

  // Mirrors a word so that left shifts can reuse the right-shift datapath.
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter64_if.sv
// Connection bundle between the issue stage FIFO head and the barrel shifter.
interface barrel_shifter64_if;
  import shift_pkg::*;

  shift_req_t        req;
  logic [DATA_W-1:0] result;

  modport host    (output req, input  result);
  modport shifter (input  req, output result);

endinterface

// File: rtl/barrel_shifter64.sv
// Combinational 64-bit logarithmic shifter; left shifts are done by mirroring
// the operand around a single right-shift ladder with zero or sign fill.
module barrel_shifter64
  import shift_pkg::*;
(
  barrel_shifter64_if.shifter bus
);

  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  logic              w_left;
  logic              w_fill;
  logic [DATA_W-1:0] w_pre;
  logic [DATA_W-1:0] w_shifted;

  assign w_left = (bus.req.shift_type == SHIFT_LL) || (bus.req.shift_type == SHIFT_LA);
  assign w_fill = (bus.req.shift_type == SHIFT_RA) && bus.req.in[DATA_W-1];
  assign w_pre  = w_left ? bit_reverse(bus.req.in) : bus.req.in;

  // One stage per amount bit, each shifting right by a power of two.
  always_comb begin
    w_shifted = w_pre;
    for (int i = 0; i < AMT_W; i++) begin
      if (bus.req.shift_amount[i]) begin
        w_shifted = (w_shifted >> (1 << i)) | (w_fill ? ~(ONES >> (1 << i)) : '0);
      end
    end
  end

  assign bus.result = w_left ? bit_reverse(w_shifted) : w_shifted;

endmodule

// File: rtl/shift_issue_stage64.sv
// Request FIFO feeding a barrel shifter whose result is captured in a
// valid/ready output register, forming a back-pressure-aware shift stage.
module shift_issue_stage64
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_W-1:0]       req_in,
  input  logic [1:0]              req_shift_type,
  input  logic [AMT_W-1:0]        req_shift_amount,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  shift_req_t         r_mem     [DEPTH];
  logic [TAG_W-1:0]   r_tag_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_res_valid;
  logic [DATA_W-1:0]  r_res_data;
  logic [TAG_W-1:0]   r_res_tag;

  logic               w_not_full;
  logic               w_head_valid;
  logic               w_push;
  logic               w_load;
  logic [DATA_W-1:0]  w_bs_result;

  assign w_not_full   = (r_count != CNT_W'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_push       = req_valid && w_not_full;
  assign w_load       = w_head_valid && (!r_res_valid || res_ready);

  barrel_shifter64_if u_bs_if ();

  assign u_bs_if.req = r_mem[r_rd_ptr];
  assign w_bs_result = u_bs_if.result;

  barrel_shifter64 u_shifter (
    .bus (u_bs_if.shifter)
  );

  // Payload storage is intentionally left unreset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]     <= '{in:           req_in,
                               shift_type:   shift_type_e'(req_shift_type),
                               shift_amount: req_shift_amount};
      r_tag_mem[r_wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: refill from the shifter whenever it is empty or being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
    end else if (w_load) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_bs_result;
      r_res_tag   <= r_tag_mem[r_rd_ptr];
    end else if (res_ready && r_res_valid) begin
      r_res_valid <= 1'b0;
    end
  end

  assign req_ready = w_not_full;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_tag   = r_res_tag;
  assign count     = r_count;

endmodule

// File: tb/tb_shift_issue_stage64.sv
// Randomized and directed bench for shift_issue_stage64 against a queue-based
// reference model of the FIFO plus output register.
module tb_shift_issue_stage64;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_in;
  logic [1:0]        req_shift_type;
  logic [5:0]        req_shift_amount;
  logic [TAG_W-1:0]  req_tag;
  logic              res_valid;
  logic              res_ready;
  logic [63:0]       res_data;
  logic [TAG_W-1:0]  res_tag;
  logic [2:0]        count;

  shift_issue_stage64 #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_in           (req_in),
    .req_shift_type   (req_shift_type),
    .req_shift_amount (req_shift_amount),
    .req_tag          (req_tag),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_tag          (res_tag),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             m_q[$];
  bit               m_valid;
  logic [63:0]      m_data;
  logic [TAG_W-1:0] m_tag;
  int               consumed[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] v, input logic [1:0] t,
                                            input logic [5:0] a);
    case (t)
      2'b00, 2'b10: return v << a;
      2'b01:        return v >> a;
      default:      return 64'($signed(v) >>> a);
    endcase
  endfunction

  task automatic set_req(input logic v, input logic [63:0] d, input logic [1:0] t,
                         input logic [5:0] a, input logic [TAG_W-1:0] g);
    req_valid        = v;
    req_in           = d;
    req_shift_type   = t;
    req_shift_amount = a;
    req_tag          = g;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_tag   = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, step past the rising edge.
  task automatic cycle();
    bit   push;
    bit   ld;
    exp_t e;
    @(negedge clk);
    check("count", 64'(count), 64'(m_q.size()));
    check("req_ready", 64'(req_ready), 64'(m_q.size() != DEPTH));
    check("res_valid", 64'(res_valid), 64'(m_valid));
    if (m_valid) begin
      check("res_data", res_data, m_data);
      check("res_tag", 64'(res_tag), 64'(m_tag));
    end
    push = req_valid && (m_q.size() != DEPTH);
    ld   = (m_q.size() > 0) && (!m_valid || res_ready);
    if (m_valid && res_ready) consumed.push_back(int'(m_tag));
    if (ld) begin
      e       = m_q.pop_front();
      m_data  = e.data;
      m_tag   = e.tag;
      m_valid = 1'b1;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    if (push) begin
      e.data = ref_shift(req_in, req_shift_type, req_shift_amount);
      e.tag  = req_tag;
      m_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_req(1'b0, '0, 2'b00, '0, '0);
    res_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) cycle();
  endtask

  logic [63:0] type_exp [4];

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    type_exp[0] = 64'hF000_0000_0000_0F00;
    type_exp[1] = 64'h00F0_F000_0000_0000;
    type_exp[2] = 64'hF000_0000_0000_0F00;
    type_exp[3] = 64'hFFF0_F000_0000_0000;

    rst       = 1'b1;
    res_ready = 1'b0;
    set_req(1'b0, '0, 2'b00, '0, '0);
    #12;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single arithmetic right shift, two-edge latency.
    res_ready = 1'b1;
    set_req(1'b1, 64'h8000_0000_0000_00F0, 2'b11, 6'd4, 4'd3);
    cycle();
    set_req(1'b0, '0, 2'b00, '0, '0);
    cycle();
    check("ra_valid", 64'(res_valid), 64'd1);
    check("ra_data", res_data, 64'hF800_0000_0000_000F);
    check("ra_tag", 64'(res_tag), 64'd3);
    cycle();

    // Every shift type on one operand.
    for (int t = 0; t < 4; t++) begin
      set_req(1'b1, 64'hF0F0_0000_0000_000F, 2'(t), 6'd8, 4'(t));
      cycle();
      set_req(1'b0, '0, 2'b00, '0, '0);
      cycle();
      check($sformatf("type%0d_data", t), res_data, type_exp[t]);
      cycle();
    end

    // Back-pressure: fill output register plus FIFO, then release.
    drain();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 64'($urandom) << 32 | 64'($urandom), 2'($urandom), 6'($urandom), 4'(i));
      cycle();
    end
    set_req(1'b0, '0, 2'b00, '0, '0);
    check("bp_count", 64'(count), 64'd4);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    check("bp_res_valid", 64'(res_valid), 64'd1);
    set_req(1'b1, 64'hDEAD_BEEF_0000_0001, 2'b01, 6'd1, 4'd9);
    cycle();
    set_req(1'b0, '0, 2'b00, '0, '0);
    consumed.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_stream_valid", 64'(res_valid), 64'd1);
      cycle();
    end
    check("bp_n_results", 64'(consumed.size()), 64'd5);
    for (int i = 0; i < consumed.size() && i < 5; i++) begin
      check("bp_order", 64'(consumed[i]), 64'(i));
    end

    // Streaming with zero shift amount.
    drain();
    consumed.delete();
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, 64'($urandom) << 32 | 64'($urandom), 2'($urandom), 6'd0, 4'(i));
      check("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      if (i >= 2) check("stream_no_gap", 64'(res_valid), 64'd1);
      cycle();
    end
    set_req(1'b0, '0, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    check("stream_n_results", 64'(consumed.size()), 64'd16);

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 200; i++) begin
      set_req(1'($urandom_range(0, 1)), 64'($urandom) << 32 | 64'($urandom),
              2'($urandom), 6'($urandom), 4'($urandom));
      res_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Asynchronous reset with work in flight.
    drain();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 64'($urandom) << 32 | 64'($urandom), 2'($urandom), 6'($urandom), 4'(i + 8));
      cycle();
    end
    set_req(1'b0, '0, 2'b00, '0, '0);
    check("mid_count", 64'(count), 64'd3);
    check("mid_res_valid", 64'(res_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_res_data", res_data, 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_stale", 64'(res_valid), 64'd0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
